// File: rtl/wlm_limb_mul_pkg.sv
// Shared types for the limb-serial multiplier feeding the word-level Montgomery stage.
// Holds the qH descriptor type, the multiplier FSM states and a ceil-div helper for limb counts.
package wlm_limb_mul_pkg;

  localparam int LOGQH_17 = 17;

  typedef logic [LOGQH_17-1:0] logqh_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } wlm_mul_state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/wlm_limb_mul_dsp.sv
// W x W unsigned multiplier, one DSP; FF_MUL=1 adds one output register (latency FF_MUL cycles).
// No flow control: a new operand pair is taken every cycle.
module wlm_limb_mul_dsp #(
  parameter int W      = 20,
  parameter int FF_MUL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  logic [2*W-1:0] prod;

  assign prod = (2*W)'(a) * (2*W)'(b);

  if (FF_MUL != 0) begin : g_ff
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) p <= '0;
      else      p <= prod;
    end
  end else begin : g_comb
    assign p = prod;
  end

endmodule

// File: rtl/wlm_limb_mul.sv
// Limb-serial A*B: NL^2 limb products through one shared multiplier, result pulsed out after NL^2+FF_MUL cycles.
// Upstream valid/ready (ready only when idle); downstream has no backpressure, out_valid is a one-cycle pulse.
module wlm_limb_mul
  import wlm_limb_mul_pkg::*;
#(
  parameter int LOGQ   = 60,
  parameter int LOGQH  = LOGQH_17,
  parameter int W      = 20,
  parameter int FF_MUL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOGQ-1:0]   A,
  input  logic [LOGQ-1:0]   B,
  input  logic [LOGQH-1:0]  qH_in,
  output logic              out_valid,
  output logic [2*LOGQ-1:0] C,
  output logic [LOGQH-1:0]  qH
);

  localparam int NL = ceil_div(LOGQ, W);
  localparam int OW = NL * W;
  localparam int AW = 2 * NL * W;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;
  localparam int SW = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(NL - 1);

  wlm_mul_state_t state, state_nxt;

  logic [OW-1:0]    a_q, b_q;
  logic [LOGQH-1:0] qh_cap;
  logic [IW-1:0]    i_q, j_q;
  logic [AW-1:0]    acc_q, acc_nxt, term;
  logic [W-1:0]     a_limb, b_limb;
  logic [2*W-1:0]   prod;
  logic             add_vld;
  logic [SW-1:0]    add_sh;
  logic             accept, issue, last;

  assign accept = (state == ST_IDLE) && in_valid;
  assign issue  = (state == ST_MUL);
  assign last   = issue && (i_q == LAST) && (j_q == LAST);

  assign a_limb = a_q[i_q*W +: W];
  assign b_limb = b_q[j_q*W +: W];

  wlm_limb_mul_dsp #(.W(W), .FF_MUL(FF_MUL)) u_dsp (
    .clk (clk),
    .rst (rst),
    .a   (a_limb),
    .b   (b_limb),
    .p   (prod)
  );

  // The limb position tag must travel alongside the product through the optional DSP register.
  if (FF_MUL != 0) begin : g_tag_ff
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        add_vld <= 1'b0;
        add_sh  <= '0;
      end else begin
        add_vld <= issue;
        add_sh  <= SW'(i_q) + SW'(j_q);
      end
    end
  end else begin : g_tag_comb
    assign add_vld = issue;
    assign add_sh  = SW'(i_q) + SW'(j_q);
  end

  always_comb begin
    term    = AW'(prod) << (add_sh * W);
    acc_nxt = acc_q;
    if (accept)       acc_nxt = '0;
    else if (add_vld) acc_nxt = acc_q + term;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_MUL;
      end
      ST_MUL: begin
        if (last) state_nxt = (FF_MUL != 0) ? ST_FLUSH : ST_DONE;
      end
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      qh_cap <= '0;
      i_q    <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      C      <= '0;
      qH     <= '0;
    end else begin
      acc_q <= acc_nxt;
      if (accept) begin
        a_q    <= OW'(A);
        b_q    <= OW'(B);
        qh_cap <= qH_in;
        i_q    <= '0;
        j_q    <= '0;
      end else if (issue) begin
        if (j_q == LAST) begin
          j_q <= '0;
          i_q <= last ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
      // Outputs are loaded on entry to DONE so they hold steady until the next result.
      if (state_nxt == ST_DONE) begin
        C  <= acc_nxt[2*LOGQ-1:0];
        qH <= qh_cap;
      end
    end
  end

endmodule

// File: doc/wlm_limb_mul.md
# wlm_limb_mul

Iterative limb-serial multiplier that computes the 2·LOGQ-bit product C = A·B and presents it, together with the modulus descriptor qH, to the word-level Montgomery reduction stage (wlm_mixed) directly downstream. It reuses one W×W multiplier over all NL² limb products, so a full-width product costs one DSP-sized multiplier instead of a full LOGQ×LOGQ array. Upstream uses a valid/ready handshake. Downstream is a free-running pipeline with no backpressure, so the result is a single-cycle valid pulse.

## Interface
- LOGQ, 60: operand width in bits.
- LOGQH, LOGQH_17 (logqh_t): width of qH, passed through unchanged.
- W, 20: limb width. NL = ceil(LOGQ/W) is a localparam.
- FF_MUL, 1: 1 = register the limb product before accumulation (adds 1 cycle latency).
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  A, B and qH_in are valid.
- in_ready  out  1  block is idle and accepts an operation.
- A  in  LOGQ  multiplicand, unsigned.
- B  in  LOGQ  multiplier, unsigned.
- qH_in  in  LOGQH  qH belonging to this operation.
- out_valid  out  1  one-cycle pulse; C and qH are valid.
- C  out  2·LOGQ  product A·B, feeds wlm_mixed.C.
- qH  out  LOGQH  captured qH_in, feeds wlm_mixed.qH.

## Operation
- States: IDLE, MUL, (FLUSH when FF_MUL=1), DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: capture A, B and qH_in; zero-extend A and B to NL·W bits.
  - Clear the accumulator (2·NL·W bits) and limb indices i, j; go to MUL.
- **MUL**
  - One limb product per cycle: p = A[i]·B[j], 2W bits unsigned.
  - Accumulate: acc += p << ((i+j)·W). The addition is full-width with no truncation.
  - Index order: j is inner, i is outer, each running 0..NL-1.
  - After the product for i=j=NL-1 is issued, go to FLUSH if FF_MUL=1, otherwise to DONE.
- **FLUSH**: one cycle that accumulates the last registered product, then go to DONE.
- **DONE**
  - out_valid=1 for exactly one cycle.
  - C holds acc[2·LOGQ-1:0]; the truncation is lossless because A, B < 2^LOGQ.
  - qH holds the captured value. Return to IDLE.
- C and qH stay stable until the next DONE, so downstream sampling within that cycle is safe.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored; upstream must hold its request.
- qH_in, A and B changes after acceptance have no effect on the current operation.
- No modular precondition (A, B < q) is checked. The product is exact for any LOGQ-bit inputs.

## Timing
- Reset values (asynchronous, while rst=0): state=IDLE, in_ready=1, out_valid=0, C=0, qH=0, accumulator and indices 0.
- Reset mid-operation aborts immediately. No out_valid is produced, and in_ready=1 once rst deasserts.
- Accept at edge e0 (in_valid && in_ready). out_valid is high in the cycle after edge e(NL²+FF_MUL).
  - Defaults (NL=3, FF_MUL=1): out_valid visible 10 cycles after e0.
- in_ready returns high in the cycle after the out_valid cycle.
- Throughput: one operation per NL²+FF_MUL+2 cycles (12 at defaults).
- Back-to-back: with in_valid held high, the next operation is accepted on the first IDLE edge. out_valid is never asserted in two consecutive cycles.

## Structure
- Shared header wlm_mixed.svh:
  - keeps the existing logqh_t;
  - gains the state typedef wlm_mul_state_t (IDLE, MUL, FLUSH, DONE);
  - gains a ceil-div constant function used for NL.
- Sub-module wlm_limb_mul_dsp: W×W unsigned multiplier with optional output register (FF_MUL), mapped to a single DSP.
- The top-level holds the FSM, the indices, the operand registers and the accumulator.

## Test plan
- Reset release, in_valid=0 -> in_ready=1, out_valid=0, C=0, qH=0 for 20 cycles.
- A=0, B=0x0FFFFFFFFFFFFFFF, qH_in=0x1ABCD -> after 10 cycles out_valid pulse, C=0, qH=0x1ABCD.
- A=B=0x0FFFFFFFFFFFFFFF -> C=0xFFFFFFFFFFFFFFE000000000000001, exactly one out_valid cycle.
- in_valid held high with two ops (A=1, B=0x123456789ABCDEF, then A=B=2) -> in_ready low while busy; second accepted 12 cycles after the first; results 0x123456789ABCDEF then 4; qH_in toggled while busy does not change qH.
- rst pulsed low 4 cycles after acceptance -> no out_valid; C=0; next op A=3, B=5 yields C=15.
- 10k random A, B < 2^60, chained into wlm_mixed -> T matches the golden T.txt vectors.
